// File: rtl/dsp_boot_ctrl.sv
// DSP boot sequencer: holds the DSP in reset with the boot-mode word on its GPIOs,
// releases reset, hands the pins to the DSP and waits for ready, retrying on timeout.
module dsp_boot_ctrl #(
   parameter logic [15:0] BOOTMODE      = 16'h160D,
   parameter int unsigned RST_CYC       = 100,
   parameter int unsigned HOLD_CYC      = 50,
   parameter int unsigned READY_TIMEOUT = 1000,
   parameter int unsigned MAX_RETRY     = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_reboot,
   input  logic        i_dsp_ready,
   output logic        o_dsp_nrst,
   output logic [15:0] o_dsp_gpio,
   output logic [15:0] o_dsp_gpio_dir_by_dsp,
   output logic        o_bootconfig_done,
   output logic        o_boot_fail,
   output logic [1:0]  o_retry_cnt,
   output logic [2:0]  o_state
);

   typedef enum logic [2:0] {
      ST_RST  = 3'd1,
      ST_HOLD = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4,
      ST_FAIL = 3'd5
   } state_t;

   localparam logic [31:0] L_RST_LAST  = 32'(RST_CYC - 1);
   localparam logic [31:0] L_HOLD_LAST = 32'(HOLD_CYC - 1);
   localparam logic [31:0] L_TO_LAST   = 32'(READY_TIMEOUT - 1);
   localparam logic [1:0]  L_MAX_RETRY = 2'(MAX_RETRY);

   logic        r_rdy_s1;
   logic        r_rdy_s2;
   logic        r_rbt_s1;
   logic        r_rbt_s2;
   logic        r_rbt_s3;
   logic        w_rdy_s;
   logic        w_reboot_evt;

   state_t      r_state;
   logic [31:0] r_cnt;
   logic        r_run;
   logic [1:0]  r_retry_cnt;
   logic        r_dsp_nrst;
   logic [15:0] r_dsp_gpio;
   logic [15:0] r_dir;
   logic        r_done;
   logic        r_fail;

   state_t      w_next_state;
   logic        w_cnt_clr;
   logic        w_retry_inc;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rdy_s1 <= 1'b0;
         r_rdy_s2 <= 1'b0;
         r_rbt_s1 <= 1'b0;
         r_rbt_s2 <= 1'b0;
         r_rbt_s3 <= 1'b0;
      end else begin
         r_rdy_s1 <= i_dsp_ready;
         r_rdy_s2 <= r_rdy_s1;
         r_rbt_s1 <= i_reboot;
         r_rbt_s2 <= r_rbt_s1;
         r_rbt_s3 <= r_rbt_s2;
      end
   end

   assign w_rdy_s      = r_rdy_s2;
   assign w_reboot_evt = r_rbt_s2 & ~r_rbt_s3;

   // Re-boot outranks everything; ready outranks the WAIT timeout.
   always_comb begin
      w_next_state = r_state;
      w_retry_inc  = 1'b0;
      if (w_reboot_evt) begin
         w_next_state = ST_RST;
      end else begin
         case (r_state)
            ST_RST:  if (r_cnt == L_RST_LAST) w_next_state = ST_HOLD;
            ST_HOLD: if (r_cnt == L_HOLD_LAST) w_next_state = ST_WAIT;
            ST_WAIT: begin
               if (w_rdy_s) begin
                  w_next_state = ST_DONE;
               end else if (r_cnt == L_TO_LAST) begin
                  if (r_retry_cnt < L_MAX_RETRY) begin
                     w_next_state = ST_RST;
                     w_retry_inc  = 1'b1;
                  end else begin
                     w_next_state = ST_FAIL;
                  end
               end
            end
            default: w_next_state = r_state;
         endcase
      end
      w_cnt_clr = w_reboot_evt | (w_next_state != r_state);
   end

   // r_run holds the counter on the first edge after reset so that reset release
   // behaves like an RST entry: RST then spans edges 0..RST_CYC-1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_RST;
         r_cnt       <= 32'd0;
         r_run       <= 1'b0;
         r_retry_cnt <= 2'd0;
         r_dsp_nrst  <= 1'b0;
         r_dsp_gpio  <= BOOTMODE;
         r_dir       <= 16'h0000;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_run   <= 1'b1;
         r_state <= w_next_state;
         if (w_cnt_clr) begin
            r_cnt <= 32'd0;
         end else if (r_run) begin
            r_cnt <= r_cnt + 32'd1;
         end
         if (w_reboot_evt) begin
            r_retry_cnt <= 2'd0;
         end else if (w_retry_inc) begin
            r_retry_cnt <= r_retry_cnt + 2'd1;
         end
         r_dsp_nrst <= (w_next_state != ST_RST) && (w_next_state != ST_FAIL);
         r_dsp_gpio <= BOOTMODE;
         r_dir      <= ((w_next_state == ST_WAIT) || (w_next_state == ST_DONE)) ? 16'hFFFF : 16'h0000;
         r_done     <= (w_next_state == ST_DONE);
         if (w_reboot_evt) begin
            r_fail <= 1'b0;
         end else if (w_next_state == ST_FAIL) begin
            r_fail <= 1'b1;
         end
      end
   end

   assign o_dsp_nrst            = r_dsp_nrst;
   assign o_dsp_gpio            = r_dsp_gpio;
   assign o_dsp_gpio_dir_by_dsp = r_dir;
   assign o_bootconfig_done     = r_done;
   assign o_boot_fail           = r_fail;
   assign o_retry_cnt           = r_retry_cnt;
   assign o_state               = r_state;

endmodule

// File: tb/tb_dsp_boot_ctrl.sv
// Directed bench for dsp_boot_ctrl with default parameters; expected edges are
// hand-computed from edge 0 = first rising clk edge after rstn release.
module tb_dsp_boot_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        i_reboot = 1'b0;
   logic        i_dsp_ready = 1'b0;
   logic        o_dsp_nrst;
   logic [15:0] o_dsp_gpio;
   logic [15:0] o_dsp_gpio_dir_by_dsp;
   logic        o_bootconfig_done;
   logic        o_boot_fail;
   logic [1:0]  o_retry_cnt;
   logic [2:0]  o_state;

   int n_chk = 0;
   int n_pass = 0;
   int cur_edge = -1;

   always #5 clk = ~clk;

   dsp_boot_ctrl dut (
      .clk                   (clk),
      .rstn                  (rstn),
      .i_reboot              (i_reboot),
      .i_dsp_ready           (i_dsp_ready),
      .o_dsp_nrst            (o_dsp_nrst),
      .o_dsp_gpio            (o_dsp_gpio),
      .o_dsp_gpio_dir_by_dsp (o_dsp_gpio_dir_by_dsp),
      .o_bootconfig_done     (o_bootconfig_done),
      .o_boot_fail           (o_boot_fail),
      .o_retry_cnt           (o_retry_cnt),
      .o_state               (o_state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance to just after edge e.
   task automatic go_edge(input int e);
      while (cur_edge < e) begin
         @(posedge clk);
         cur_edge++;
      end
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(o_state), 32'd1);
      chk({tag, "_nrst"}, 32'(o_dsp_nrst), 32'd0);
      chk({tag, "_gpio"}, 32'(o_dsp_gpio), 32'h160D);
      chk({tag, "_dir"}, 32'(o_dsp_gpio_dir_by_dsp), 32'h0);
      chk({tag, "_done"}, 32'(o_bootconfig_done), 32'd0);
      chk({tag, "_fail"}, 32'(o_boot_fail), 32'd0);
      chk({tag, "_retry"}, 32'(o_retry_cnt), 32'd0);
   endtask

   task automatic restart(input logic rdy, input logic rbt);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      i_dsp_ready = rdy;
      i_reboot = rbt;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      cur_edge = -1;
   endtask

   initial begin
      // Reset values while rstn is low
      i_dsp_ready = 1'b1;
      #12;
      chk_reset_vals("rst");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      cur_edge = -1;

      // Asynchronous reset in the middle of HOLD
      go_edge(120);
      chk("hold120_state", 32'(o_state), 32'd2);
      chk("hold120_nrst", 32'(o_dsp_nrst), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk_reset_vals("async");
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      cur_edge = -1;

      // Nominal boot, ready high throughout
      go_edge(99);
      chk("nom99_nrst", 32'(o_dsp_nrst), 32'd0);
      chk("nom99_state", 32'(o_state), 32'd1);
      go_edge(100);
      chk("nom100_nrst", 32'(o_dsp_nrst), 32'd1);
      chk("nom100_state", 32'(o_state), 32'd2);
      chk("nom100_dir", 32'(o_dsp_gpio_dir_by_dsp), 32'h0);
      go_edge(149);
      chk("nom149_dir", 32'(o_dsp_gpio_dir_by_dsp), 32'h0);
      go_edge(150);
      chk("nom150_dir", 32'(o_dsp_gpio_dir_by_dsp), 32'hFFFF);
      chk("nom150_state", 32'(o_state), 32'd3);
      chk("nom150_done", 32'(o_bootconfig_done), 32'd0);
      go_edge(153);
      chk("nom153_done", 32'(o_bootconfig_done), 32'd1);
      chk("nom153_state", 32'(o_state), 32'd4);
      chk("nom153_gpio", 32'(o_dsp_gpio), 32'h160D);

      // Re-boot from DONE
      go_edge(160);
      i_reboot = 1'b1;
      go_edge(162);
      chk("rbd162_state", 32'(o_state), 32'd4);
      go_edge(163);
      chk("rbd163_state", 32'(o_state), 32'd1);
      chk("rbd163_done", 32'(o_bootconfig_done), 32'd0);
      chk("rbd163_nrst", 32'(o_dsp_nrst), 32'd0);
      chk("rbd163_retry", 32'(o_retry_cnt), 32'd0);
      i_reboot = 1'b0;
      go_edge(262);
      chk("rbd262_nrst", 32'(o_dsp_nrst), 32'd0);
      go_edge(263);
      chk("rbd263_nrst", 32'(o_dsp_nrst), 32'd1);
      go_edge(320);
      chk("rbd320_done", 32'(o_bootconfig_done), 32'd1);

      // i_reboot already high at reset release restarts RST at edge 2
      restart(1'b1, 1'b1);
      go_edge(100);
      chk("rhi100_nrst", 32'(o_dsp_nrst), 32'd0);
      go_edge(102);
      chk("rhi102_nrst", 32'(o_dsp_nrst), 32'd1);
      chk("rhi102_state", 32'(o_state), 32'd2);

      // Single timeout then recovery
      restart(1'b0, 1'b0);
      go_edge(1149);
      chk("rec1149_state", 32'(o_state), 32'd3);
      chk("rec1149_retry", 32'(o_retry_cnt), 32'd0);
      go_edge(1150);
      chk("rec1150_state", 32'(o_state), 32'd1);
      chk("rec1150_retry", 32'(o_retry_cnt), 32'd1);
      chk("rec1150_nrst", 32'(o_dsp_nrst), 32'd0);
      chk("rec1150_dir", 32'(o_dsp_gpio_dir_by_dsp), 32'h0);
      go_edge(1249);
      chk("rec1249_nrst", 32'(o_dsp_nrst), 32'd0);
      go_edge(1250);
      chk("rec1250_nrst", 32'(o_dsp_nrst), 32'd1);
      go_edge(1310);
      i_dsp_ready = 1'b1;
      go_edge(1312);
      chk("rec1312_state", 32'(o_state), 32'd3);
      chk("rec1312_done", 32'(o_bootconfig_done), 32'd0);
      go_edge(1313);
      chk("rec1313_state", 32'(o_state), 32'd4);
      chk("rec1313_done", 32'(o_bootconfig_done), 32'd1);
      chk("rec1313_retry", 32'(o_retry_cnt), 32'd1);
      i_dsp_ready = 1'b0;
      go_edge(1320);
      chk("rec1320_done_kept", 32'(o_bootconfig_done), 32'd1);

      // Ready and timeout on the same edge
      restart(1'b0, 1'b0);
      go_edge(1147);
      i_dsp_ready = 1'b1;
      go_edge(1149);
      chk("prr1149_state", 32'(o_state), 32'd3);
      go_edge(1150);
      chk("prr1150_state", 32'(o_state), 32'd4);
      chk("prr1150_retry", 32'(o_retry_cnt), 32'd0);

      // Total failure
      restart(1'b0, 1'b0);
      go_edge(2300);
      chk("tf2300_retry", 32'(o_retry_cnt), 32'd2);
      go_edge(3450);
      chk("tf3450_retry", 32'(o_retry_cnt), 32'd3);
      chk("tf3450_state", 32'(o_state), 32'd1);
      go_edge(4599);
      chk("tf4599_state", 32'(o_state), 32'd3);
      chk("tf4599_fail", 32'(o_boot_fail), 32'd0);
      go_edge(4600);
      chk("tf4600_state", 32'(o_state), 32'd5);
      chk("tf4600_fail", 32'(o_boot_fail), 32'd1);
      chk("tf4600_nrst", 32'(o_dsp_nrst), 32'd0);
      chk("tf4600_dir", 32'(o_dsp_gpio_dir_by_dsp), 32'h0);
      chk("tf4600_retry", 32'(o_retry_cnt), 32'd3);
      go_edge(4610);
      chk("tf4610_state", 32'(o_state), 32'd5);

      // Re-boot from FAIL
      i_reboot = 1'b1;
      go_edge(4613);
      chk("rbf4613_state", 32'(o_state), 32'd1);
      chk("rbf4613_fail", 32'(o_boot_fail), 32'd0);
      chk("rbf4613_retry", 32'(o_retry_cnt), 32'd0);
      chk("rbf4613_done", 32'(o_bootconfig_done), 32'd0);
      i_reboot = 1'b0;

      // Re-boot and WAIT timeout on the same edge (timeout due at 5763)
      go_edge(5760);
      i_reboot = 1'b1;
      go_edge(5762);
      chk("prb5762_state", 32'(o_state), 32'd3);
      go_edge(5763);
      chk("prb5763_state", 32'(o_state), 32'd1);
      chk("prb5763_retry", 32'(o_retry_cnt), 32'd0);
      chk("prb5763_nrst", 32'(o_dsp_nrst), 32'd0);
      i_reboot = 1'b0;
      go_edge(5862);
      chk("prb5862_nrst", 32'(o_dsp_nrst), 32'd0);
      go_edge(5863);
      chk("prb5863_nrst", 32'(o_dsp_nrst), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dsp_boot_ctrl.md
# dsp_boot_ctrl

Boot sequencer for the DSP, sitting directly upstream of `gpio_top`. It holds the DSP in reset while presenting the boot-mode word on the DSP GPIO pins, then releases reset and hands pin ownership to the DSP. It waits for the DSP's ready indication and asserts `bootconfig_done`, retrying the reset sequence on timeout. Its outputs drive `gpio_top` inputs `i_dsp_gpio`, `i_dsp_gpio_dir_by_dsp_re` and `i_dsp_bootconfig_done`, plus the DSP reset pin.

## Interface
- `BOOTMODE`, default `16'h160D`: boot-mode word driven while the FPGA owns the pins.
- `RST_CYC`, default 100: cycles `o_dsp_nrst` is held low per attempt (≥1).
- `HOLD_CYC`, default 50: cycles the boot-mode word is held after reset release (≥1).
- `READY_TIMEOUT`, default 1000: maximum WAIT cycles per attempt (≥1).
- `MAX_RETRY`, default 3: retries after the first attempt (0..3).

Ports:
- `clk`, in, 1: clock. Same clock as `gpio_top` `mainclkdiv8`.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `i_reboot`, in, 1: asynchronous. A rising edge requests a full re-boot.
- `i_dsp_ready`, in, 1: asynchronous, from the DSP. High means boot complete.
- `o_dsp_nrst`, out, 1: DSP reset, active-low.
- `o_dsp_gpio`, out, 16: value the FPGA drives onto the DSP GPIO pins.
- `o_dsp_gpio_dir_by_dsp`, out, 16: per bit, 1 = DSP owns the pin, 0 = FPGA drives it.
- `o_bootconfig_done`, out, 1: boot complete.
- `o_boot_fail`, out, 1: all attempts timed out. Sticky.
- `o_retry_cnt`, out, 2: retries consumed.
- `o_state`, out, 3: current state code.

## Operation
- Input synchronisers:
  - `i_dsp_ready` passes through 2 flops, giving `rdy_s`.
  - `i_reboot` passes through 2 flops plus one delay flop; `reboot_evt = s2 & ~s3`.
  - All synchroniser flops reset to 0.
- States, with codes and output values:
  - RST = 1: `nrst`=0, `dir`=0000, `done`=0.
  - HOLD = 2: `nrst`=1, `dir`=0000.
  - WAIT = 3: `nrst`=1, `dir`=FFFF.
  - DONE = 4: `nrst`=1, `dir`=FFFF, `done`=1.
  - FAIL = 5: `nrst`=0, `dir`=0000, `fail`=1.
- `o_dsp_gpio` is `BOOTMODE` in every state.
- A 32-bit state counter `cnt` clears on every state entry and otherwise increments.
- Transitions:
  - RST → HOLD when `cnt == RST_CYC-1`.
  - HOLD → WAIT when `cnt == HOLD_CYC-1`.
  - WAIT → DONE when `rdy_s == 1`.
  - WAIT, timeout (`cnt == READY_TIMEOUT-1` and `rdy_s == 0`):
    - if `retry_cnt < MAX_RETRY`: increment `retry_cnt` and go to RST;
    - otherwise go to FAIL.
  - DONE and FAIL are held until `reboot_evt`. In DONE, a falling `rdy_s` is ignored.
- `reboot_evt` in any state, including RST:
  - go to RST with `cnt` cleared;
  - `retry_cnt` = 0;
  - `o_boot_fail` cleared.
  - It has priority over every other transition, including a timeout or ready in the same cycle.
- `rdy_s` rising in the same cycle as the WAIT timeout goes to DONE: ready has priority over timeout.
- All outputs are registered. They are Moore-decoded from the next state, so each output changes on the same edge as the state register.

## Timing
- Reset values:
  - `state` = RST, `cnt` = 0;
  - `o_dsp_nrst` = 0, `o_dsp_gpio` = `BOOTMODE`, `o_dsp_gpio_dir_by_dsp` = 0000;
  - `o_bootconfig_done` = 0, `o_boot_fail` = 0, `o_retry_cnt` = 0, `o_state` = 1.
- Edge numbering: edge 0 is the first `clk` rising edge with `rstn` high.
  - RST occupies edges 0..`RST_CYC-1`.
  - `o_dsp_nrst` rises at edge `RST_CYC`.
  - `dir` goes to FFFF at edge `RST_CYC+HOLD_CYC`.
- Ready latency: `i_dsp_ready` reaches `rdy_s` after 2 edges. DONE follows on the next edge, so `done` rises 3 edges after `i_dsp_ready` rises (when already in WAIT).
  - If `rdy_s` is already 1 on entering WAIT, WAIT lasts exactly 1 cycle.
- Reboot latency: from an `i_reboot` rising edge, the state is RST and `nrst` = 0 after 3 edges.
- `i_reboot` already high at reset release produces one `reboot_evt` at edge 2, which restarts RST. This behaviour is required.
- Asynchronous `rstn` assertion at any point forces the reset values immediately, without waiting for `clk`.

## Test plan
- **Nominal boot.** `i_dsp_ready` = 1 from reset.
  - `nrst` rises at edge 100; `dir` = FFFF at edge 150; `done` = 1 at edge 153.
  - `o_dsp_gpio` = 16'h160D throughout.
- **Single timeout then recovery.** `i_dsp_ready` = 0 for the first attempt, set to 1 during the second WAIT.
  - `retry_cnt` = 1 at edge 1150; `nrst` low for 100 cycles; `done` = 1 after the second attempt.
- **Total failure.** `i_dsp_ready` = 0 permanently.
  - Four attempts of 1150 cycles each.
  - FAIL entered at edge 4600 with `retry_cnt` = 3, `fail` = 1, `nrst` = 0, `dir` = 0000.
- **Reboot from DONE and from FAIL.** Pulse `i_reboot`.
  - 3 edges later: state 1, `done` = 0, `fail` = 0, `retry_cnt` = 0.
  - A full sequence then repeats.
- **Priority.** Force `reboot_evt` and the WAIT timeout on the same edge: RST with `retry_cnt` = 0.
  - Force `rdy_s` and the timeout on the same edge: DONE.
- **Async reset mid-HOLD.** Drop `rstn` at cycle 120.
  - Outputs take their reset values immediately; the sequence restarts from edge 0 after release.
